// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer for a single-port, synchronous-read, word-organised data memory.
// Sub-word stores are done as read-modify-write; misaligned and reserved-size requests are rejected.
module data_mem_ctrl #(
   parameter int address_width = 12,
   parameter int data_width    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [address_width-1:0] req_addr,
   input  logic [data_width-1:0]    req_wdata,
   output logic                     resp_valid,
   output logic                     resp_err,
   output logic [data_width-1:0]    resp_rdata,
   output logic                     mem_write,
   output logic [address_width-1:0] mem_address,
   output logic [data_width-1:0]    mem_write_data,
   input  logic [data_width-1:0]    mem_read_data
);
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
   state_t state_q, state_d;
   logic write_q, write_d, unsigned_q, unsigned_d, err_q, err_d, bad;
   logic [1:0] size_q, size_d;
   logic [address_width-1:0] addr_q, addr_d;
   logic [data_width-1:0] wdata_q, wdata_d, rdata_q, rdata_d, lane, mask, ext;
   logic [4:0] sh;
   always_comb begin
      bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      sh = size_q == 2'b01 ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
      mask = size_q == 2'b00 ? 32'h0000_00ff << sh : 32'h0000_ffff << sh;
      lane = mem_read_data >> sh;
      ext = size_q == 2'b10 ? mem_read_data :
            size_q == 2'b01 ? {{16{lane[15] & ~unsigned_q}}, lane[15:0]} :
                              {{24{lane[7] & ~unsigned_q}}, lane[7:0]};
      state_d = state_q;
      write_d = write_q;
      size_d = size_q;
      unsigned_d = unsigned_q;
      err_d = err_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (req_valid) begin
            write_d = req_write;
            size_d = req_size;
            unsigned_d = req_unsigned;
            err_d = bad;
            addr_d = req_addr;
            wdata_d = req_wdata;
            state_d = bad ? RESP : (req_write && req_size == 2'b10) ? WR : RD;
         end
         RD: state_d = CAP;
         CAP: begin
            // wdata_q is reused to hold the merged word for the following write
            if (write_q) wdata_d = (mem_read_data & ~mask) | ((wdata_q << sh) & mask);
            else rdata_d = ext;
            state_d = write_q ? WR : RESP;
         end
         WR: state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q <= 2'b00;
         unsigned_q <= 1'b0;
         err_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q <= size_d;
         unsigned_q <= unsigned_d;
         err_q <= err_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
   assign req_ready = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_err = resp_valid && err_q;
   assign resp_rdata = rdata_q;
   assign mem_write = state_q == WR;
   assign mem_address = (state_q == RD || state_q == WR) ? addr_q : '0;
   assign mem_write_data = mem_write ? wdata_q : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: byte-level memory model plus per-cycle timeline compare, directed and random requests.
module tb_data_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0] req_size = 2'b00;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic req_ready, resp_valid, resp_err, mem_write;
   logic [31:0] resp_rdata, mem_write_data;
   logic [31:0] mem_read_data = '0;
   logic [11:0] mem_address;
   logic [31:0] phys [1024];
   logic [7:0] rb [4096];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.address_width(12), .data_width(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_write(mem_write),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always @(posedge clk)
      if (mem_write) phys[mem_address[11:2]] <= mem_write_data;
      else mem_read_data <= phys[mem_address[11:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: byte-addressed memory, outputs predicted per cycle offset from the accept edge
   bit busy = 1'b0;
   int k = 0, len = 0;
   logic m_store = 1'b0, m_err = 1'b0;
   logic [11:0] m_addr = '0;
   logic [31:0] m_val = '0, m_wd = '0, held = '0;

   always @(negedge clk) begin
      bit e_ready, fin, e_we, e_adr;
      int a, nb, base;
      logic [31:0] v;
      if (!rst_n) begin
         busy = 1'b0;
         held = '0;
      end else if (busy) k++;
      fin = busy && k == len;
      if (fin && !m_store && !m_err) held = m_val;
      e_ready = !busy;
      e_we = busy && m_store && !m_err && k == len - 1;
      e_adr = busy && !m_err && (k == 1 || (m_store && k == len - 1));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(fin));
      chk("resp_err", 32'(resp_err), 32'(fin && m_err));
      chk("resp_rdata", resp_rdata, held);
      chk("mem_write", 32'(mem_write), 32'(e_we));
      chk("mem_address", 32'(mem_address), e_adr ? 32'(m_addr) : 32'h0);
      chk("mem_write_data", mem_write_data, e_we ? m_wd : 32'h0);
      if (fin) busy = 1'b0;
      if (rst_n && e_ready && req_valid) begin
         a = int'(req_addr);
         base = a & ~3;
         nb = req_size == 2'b00 ? 1 : req_size == 2'b01 ? 2 : 4;
         m_addr = req_addr;
         m_store = req_write;
         m_err = req_size == 2'b11 || (req_size == 2'b01 && a % 2 != 0) || (req_size == 2'b10 && a % 4 != 0);
         if (m_err) len = 1;
         else if (req_write) begin
            for (int i = 0; i < nb; i++) rb[a + i] = req_wdata[8*i +: 8];
            m_wd = {rb[base + 3], rb[base + 2], rb[base + 1], rb[base]};
            len = nb == 4 ? 2 : 4;
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[a + i];
            for (int i = nb; i < 4; i++) v[8*i +: 8] = (!req_unsigned && v[8*nb-1]) ? 8'hff : 8'h00;
            m_val = v;
            len = 3;
         end
         busy = 1'b1;
         k = 0;
      end
   end

   task automatic req(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a,
                      input logic [31:0] d, input bit keep,
                      output logic [31:0] rd, output logic er, output int lat);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 expected 1");
      end
      @(posedge clk); #1;
      if (!keep) begin
         req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
         req_unsigned = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
      end
      lat = 1;
      while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      if (!resp_valid) begin
         checks++; errors++;
         $display("FAIL resp_timeout: resp_valid stayed 0 expected 1");
      end
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd, d;
      logic er;
      int lat, r;
      logic [11:0] a;
      for (int i = 0; i < 4096; i++) rb[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) phys[i] = {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 32'(req_ready), 32'h1);
      chk("reset_resp_valid", 32'(resp_valid), 32'h0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk("reset_mem_write", 32'(mem_write), 32'h0);
      chk("reset_mem_address", 32'(mem_address), 32'h0);
      rst_n = 1'b1;
      req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, rd, er, lat);
      chk("sw_lat", lat, 2);
      chk("sw_err", 32'(er), 32'h0);
      req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, rd, er, lat);
      chk("lw_lat", lat, 3);
      chk("lw_data", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(er), 32'h0);
      req(1'b1, 2'b00, 1'b0, 12'h012, 32'h00000055, 1'b0, rd, er, lat);
      chk("sb_lat", lat, 4);
      req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, rd, er, lat);
      chk("sb_merge", rd, 32'hDE55BEEF);
      req(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01, 1'b0, rd, er, lat);
      req(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 1'b0, rd, er, lat);
      chk("lb_011", rd, 32'h0000007F);
      req(1'b0, 2'b00, 1'b0, 12'h012, 32'h0, 1'b0, rd, er, lat);
      chk("lb_012", rd, 32'hFFFFFFFF);
      req(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 1'b0, rd, er, lat);
      chk("lhu_012", rd, 32'h000080FF);
      req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 1'b0, rd, er, lat);
      chk("lh_012", rd, 32'hFFFF80FF);
      req(1'b1, 2'b01, 1'b0, 12'h013, 32'h1234, 1'b0, rd, er, lat);
      chk("sh_mis_lat", lat, 1);
      chk("sh_mis_err", 32'(er), 32'h1);
      req(1'b0, 2'b10, 1'b0, 12'h016, 32'h0, 1'b0, rd, er, lat);
      chk("lw_mis_lat", lat, 1);
      chk("lw_mis_err", 32'(er), 32'h1);
      req(1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, 1'b0, rd, er, lat);
      chk("rsv_lat", lat, 1);
      chk("rsv_err", 32'(er), 32'h1);
      req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, rd, er, lat);
      chk("unchanged", rd, 32'h80FF7F01);
      // Byte store rewriting the byte already there, so it does not matter whether the cut-off write lands
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 12'h010; req_wdata = 32'h00000001;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wr_before_reset", 32'(mem_write), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_mem_write", 32'(mem_write), 32'h0);
      chk("async_mem_address", 32'(mem_address), 32'h0);
      chk("async_mem_wdata", mem_write_data, 32'h0);
      chk("async_ready", 32'(req_ready), 32'h1);
      chk("async_resp_valid", 32'(resp_valid), 32'h0);
      chk("async_rdata", resp_rdata, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, rd, er, lat);
      chk("after_reset_load", rd, 32'h80FF7F01);
      for (int i = 0; i < 6; i++) begin
         a = 12'($urandom_range(0, 15) * 4);
         d = $urandom;
         req(1'b1, 2'b10, 1'b0, a, d, 1'b1, rd, er, lat);
         chk("b2b_store_lat", lat, 2);
         req(1'b0, 2'b10, 1'b0, a, 32'h0, 1'b1, rd, er, lat);
         chk("b2b_load_lat", lat, 3);
         chk("b2b_load_data", rd, d);
      end
      req_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         req(1'($urandom), r < 3 ? 2'b00 : r < 6 ? 2'b01 : r < 9 ? 2'b10 : 2'b11, 1'($urandom),
             12'($urandom_range(0, 63)), $urandom, 1'($urandom), rd, er, lat);
         req_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
